dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 105 ++++++++++
 tb/tb_dmem_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port word memory behind a valid/ready request and a fixed-latency
// one-cycle response strobe. One access in flight at a time.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDXW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              accept, commit;

    logic              we_p0;
    logic [31:0]       addr_p0;
    logic [31:0]       wdata_p0;
    logic              fault_p0;
    logic [IDXW-1:0]   idx_p0;

    logic [31:0]       rdata_p1;
    logic              err_p1;

    logic [31:0]       mem [DEPTH];

    assign accept   = (state == IDLE) && req_valid;
    assign commit   = (state == WAIT) && (cnt == 4'd0);
    assign fault_p0 = (addr_p0[1:0] != 2'b00) || (addr_p0[31:2] >= 30'(DEPTH));
    assign idx_p0   = addr_p0[IDXW+1:2];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = WAIT;
                    cnt_nxt   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_p1;
                resp_err   = err_p1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // p0: request capture; held unchanged while WAIT/RESP ignore the inputs
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= req_we;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
    end

    // p1: array access on the WAIT->RESP edge; outputs are gated to RESP only
    always_ff @(posedge clk) begin
        if (commit) begin
            rdata_p1 <= (we_p0 || fault_p0) ? 32'd0 : mem[idx_p0];
            err_p1   <= fault_p0;
        end
    end

    // A reset landing on the commit edge abandons the store.
    always_ff @(posedge clk) begin
        if (commit && !reset && we_p0 && !fault_p0)
            mem[idx_p0] <= wdata_p0;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses are queued at request
// acceptance and checked (value and arrival cycle) when resp_valid appears.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        l1_ready, l1_valid, l1_err;
    logic [31:0] l1_rdata;
    logic        l15_ready, l15_valid, l15_err;
    logic [31:0] l15_rdata;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err));

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(l1_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(l1_valid), .resp_rdata(l1_rdata), .resp_err(l1_err));

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(15)) u_l15 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(l15_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(l15_valid), .resp_rdata(l15_rdata), .resp_err(l15_err));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mem_m [DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        mon_en   = 1'b0;
    int          l1_first  = -1;
    int          l15_first = -1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic m_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    endfunction

    task automatic push_exp(input logic we, input logic [31:0] a, input logic [31:0] d, input int c0);
        exp_t e;
        e.due = c0 + LAT;
        if (m_fault(a)) begin
            e.rdata = 32'd0;
            e.err   = 1'b1;
        end else if (we) begin
            mem_m[a[7:2]] = d;
            e.rdata = 32'd0;
            e.err   = 1'b0;
        end else begin
            e.rdata = mem_m[a[7:2]];
            e.err   = 1'b0;
        end
        sb.push_back(e);
    endtask

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic push, output int c0);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check_val("rdy_timeout", 32'd0, 32'd1);
            c0 = -1;
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        c0 = cyc;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (push) push_exp(we, a, d, c0);
        @(negedge clk);
        check_val("rdy_busy", {31'd0, req_ready}, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) check_val("drain_timeout", sb.size(), 32'd0);
        @(negedge clk);
    endtask

    // Response monitor: every resp_valid must match the head of the scoreboard
    // in value and cycle; outside a response the data/err lines must be 0.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && cyc > sb[0].due) begin
                check_val("resp_missing", 32'd0, 32'd1);
                sb.delete(0);
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check_val("resp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_val("resp_cycle", cyc, mon_e.due);
                    check_val("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
                    check_val("resp_rdata", resp_rdata, mon_e.rdata);
                end
            end else begin
                check_val("idle_rdata", resp_rdata, 32'd0);
                check_val("idle_err", {31'd0, resp_err}, 32'd0);
            end
            if (l1_valid && l1_first < 0)   l1_first  <= cyc;
            if (l15_valid && l15_first < 0) l15_first <= cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c_first, next_acc, n;
        logic we;
        logic [31:0] a, d;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_valid", {31'd0, resp_valid}, 32'd0);
        check_val("rst_rdata", resp_rdata, 32'd0);
        check_val("rst_err", {31'd0, resp_err}, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        // basic store/load; the first request also times the LATENCY=1/15 builds
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b1, c_first);
        drain();
        do_req(1'b0, 32'h10, 32'h0, 1'b1, c0);
        drain();

        // misaligned accesses fault and leave the array untouched
        do_req(1'b1, 32'h0, 32'hCAFE0001, 1'b1, c0);
        do_req(1'b0, 32'h102, 32'h0, 1'b1, c0);
        do_req(1'b0, 32'h2, 32'h0, 1'b1, c0);
        do_req(1'b1, 32'h3, 32'h00000BAD, 1'b1, c0);
        do_req(1'b0, 32'h0, 32'h0, 1'b1, c0);
        drain();

        // range boundary: last word valid, first word past DEPTH faults
        do_req(1'b1, 32'hFC, 32'h12345678, 1'b1, c0);
        do_req(1'b1, 32'h100, 32'h55555555, 1'b1, c0);
        do_req(1'b0, 32'hFC, 32'h0, 1'b1, c0);
        do_req(1'b0, 32'h8000_0000, 32'h0, 1'b1, c0);
        drain();

        for (int i = 0; i < 8; i++)
            do_req(1'b1, 32'(i * 4), 32'h0101_0101 * (i + 1), 1'b1, c0);
        drain();

        // req_valid held high with new inputs every cycle
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        next_acc = cyc + 1;
        req_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            we = i[0];
            a  = 32'((i % 8) * 4);
            d  = $urandom;
            req_we = we; req_addr = a; req_wdata = d;
            check_val("hold_ready", {31'd0, req_ready}, {31'd0, (cyc + 1 == next_acc)});
            @(posedge clk);
            #1;
            if (cyc == next_acc) begin
                push_exp(we, a, d, cyc);
                next_acc = next_acc + LAT + 2;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        drain();
        for (int i = 0; i < 8; i++)
            do_req(1'b0, 32'(i * 4), 32'h0, 1'b1, c0);
        drain();

        // reset while in WAIT abandons the store
        do_req(1'b1, 32'h20, 32'h11111111, 1'b1, c0);
        drain();
        do_req(1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, c0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("wait_rst_ready", {31'd0, req_ready}, 32'd1);
        repeat (8) @(negedge clk);
        do_req(1'b0, 32'h20, 32'h0, 1'b1, c0);
        drain();

        // reset wins over a simultaneous request
        @(negedge clk);
        reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hBBBBBBBB;
        @(posedge clk);
        #1;
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check_val("prio_ready", {31'd0, req_ready}, 32'd1);
        repeat (6) @(negedge clk);
        do_req(1'b0, 32'h20, 32'h0, 1'b1, c0);
        drain();

        check_val("lat1_cycle", l1_first, c_first + 1);
        check_val("lat15_cycle", l15_first, c_first + 15);
        check_val("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
